stream_demux_1_2: RTL and testbench
===================================

Name: stream_demux_1_2

Overview:
- Valid/ready stream demultiplexer; the splitting counterpart of the 2:1 select mux used in the datapath.
- One input stream with a per-beat select is steered to one of two output streams.
- Each output has a 2-entry buffer, giving full throughput with registered output valid/data.
- Used where one producer (e.g. a result bus) feeds two consumers, such as a register-file write path and a memory-store path.

Parameters:
- SIZE, 5, data width in bits of in_data, out0_data and out1_data.
- DEPTH, 2, entries per output buffer. Fixed at 2; any other value is out of scope.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  input beat accepted this cycle when in_valid is also 1.
- in_sel  input  1  destination: 0 = out0, 1 = out1. Sampled only when in_valid is 1.
- in_data  input  SIZE  input payload.
- out0_valid  output  1  out0 buffer head is valid.
- out0_ready  input  1  out0 consumer accepts the head.
- out0_data  output  SIZE  out0 head payload.
- out1_valid  output  1  out1 buffer head is valid.
- out1_ready  input  1  out1 consumer accepts the head.
- out1_data  output  SIZE  out1 head payload.
- out0_cnt  output  16  beats delivered on out0 (present only when the optional feature is enabled).
- out1_cnt  output  16  beats delivered on out1 (present only when the optional feature is enabled).

Behaviour:
- Reset (async assert, sync release):
  - both buffers empty: count=0, read/write pointers 0.
  - out0_valid=0, out1_valid=0.
  - out0_data and out1_data = 0.
  - counters = 0.
- Buffer state per output: count in {0,1,2}, a write pointer and a read pointer (1 bit each, wrap 1->0).
  - Head data is a register read at the read pointer. No combinational path from in_data to outX_data.
- in_ready = not full(selected buffer), i.e. in_sel ? (cnt1!=2) : (cnt0!=2).
  - Combinational from in_sel and registered state only. It never depends on outX_ready.
- Push: in_valid & in_ready writes in_data into the selected buffer at the write pointer and advances that pointer.
- Pop: outX_valid & outX_ready advances the read pointer.
- Per-buffer count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- Latency: a beat accepted at edge t is presented on outX_valid/outX_data from edge t (i.e. visible in cycle t+1). Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle per output when its consumer holds ready=1.
- Full: when count=2, in_ready=0 for that sel, even if a pop occurs the same cycle. This is deliberate and removes the ready-to-ready combinational path.
  - The non-selected output's state has no effect on in_ready.
- Empty: outX_valid=0. outX_data holds its last value; it is not cleared.
- Ordering: beats to the same output leave in acceptance order. No ordering is guaranteed between out0 and out1.
- Only one buffer can be pushed per cycle; both buffers may pop in the same cycle.
- outX_valid, once asserted, stays asserted until popped, independent of outX_ready.
- in_valid=0: in_sel and in_data are ignored.
- Reset asserted mid-operation: all buffered beats are dropped and valids fall immediately (asynchronously).

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined:
  - out0_cnt/out1_cnt ports exist.
  - Each increments by 1 on a pop of its output and wraps 16'hFFFF -> 0.
  - Reset value is 0.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package stream_pkg:
  - localparam STREAM_BUF_DEPTH = 2.
  - typedef enum logic {SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1} demux_sel_e.
  - localparam CNT_W = 16.
- One sub-module, stream_buf2 #(SIZE):
  - 2-entry buffer with push/pop, full, valid and head data.
  - Instantiated twice.
  - The top level holds only the steering logic and the optional counters.

Test Plan:
- Reset then idle: all valids 0, in_ready=1 for both sel values, data 0.
- Single route: in_valid=1, in_sel=0, in_data=5'h0A, out0_ready=1 for one cycle -> out0_valid=1 with 5'h0A the next cycle, out1_valid stays 0.
- Backpressure fill: out1_ready=0; push 5'h01, 5'h02 to sel=1 -> in_ready=0 for sel=1 but 1 for sel=0. Then out1_ready=1 -> 01 then 02, in order, one cycle each.
- Full plus simultaneous pop: out0 buffer full, out0_ready=1, in_valid=1, sel=0 -> no accept that cycle (in_ready=0); accept succeeds the following cycle.
- Streaming: 20 alternating-sel beats, data 0..19, both readies held at 1 -> no stall. out0 sees the even values in order, out1 the odd values. With STREAM_DEMUX_CNT_EN: out0_cnt=10, out1_cnt=10.
- Reset mid-stream: both buffers hold 1 beat, assert rst_n=0 asynchronously -> valids drop the same cycle. After release: empty, in_ready=1.

Source files
------------

// File: rtl/stream_demux_1_2_pkg.sv
// stream_pkg: shared constants and select encoding for the stream demux
package stream_pkg;
  localparam int STREAM_BUF_DEPTH = 2;
  localparam int CNT_W = 16;
  typedef enum logic {SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1} demux_sel_e;
endpackage

// File: rtl/stream_demux_1_2_buf2.sv
// stream_buf2: 2-entry buffer with registered head valid/data
// Ports: clk, rst_n (async active-low); i_push/i_data write a beat (caller
// guarantees not full); i_pop is qualified internally with o_valid;
// o_full, o_valid, o_data expose buffer state and the registered head.
module stream_buf2
  import stream_pkg::*;
#(
  parameter int SIZE = 5,
  parameter int DEPTH = STREAM_BUF_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic [SIZE-1:0] i_data,
  input  logic            i_pop,
  output logic            o_full,
  output logic            o_valid,
  output logic [SIZE-1:0] o_data
);
  logic [SIZE-1:0] r_mem [DEPTH];
  logic            r_wp;
  logic            r_rp;
  logic [1:0]      r_cnt;
  logic [SIZE-1:0] r_head;
  logic            w_pop;
  logic            w_rp_nxt;
  logic [1:0]      w_cnt_nxt;
  assign o_valid   = r_cnt != 2'd0;
  assign o_full    = r_cnt == 2'd2;
  assign o_data    = r_head;
  assign w_pop     = i_pop & o_valid;
  assign w_rp_nxt  = r_rp ^ w_pop;
  assign w_cnt_nxt = r_cnt + {1'b0, i_push} - {1'b0, w_pop};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp   <= 1'b0;
      r_rp   <= 1'b0;
      r_cnt  <= 2'd0;
      r_head <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      r_rp  <= w_rp_nxt;
      r_cnt <= w_cnt_nxt;
      // next head is the incoming beat when it lands in the slot the read
      // pointer moves to; when the buffer drains the head keeps its last value
      if (w_cnt_nxt != 2'd0)
        r_head <= (i_push && r_wp == w_rp_nxt) ? i_data : r_mem[w_rp_nxt];
    end
  end
endmodule

// File: rtl/stream_demux_1_2.sv
// stream_demux_1_2: valid/ready 1:2 stream demultiplexer with per-output 2-entry buffers
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_sel/in_data input
// stream; outX_valid/outX_ready/outX_data output streams (X = 0,1).
// Optional macro STREAM_DEMUX_CNT_EN adds out0_cnt/out1_cnt delivered-beat counters.
module stream_demux_1_2
  import stream_pkg::*;
#(
  parameter int SIZE = 5,
  parameter int DEPTH = STREAM_BUF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [SIZE-1:0]  in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [SIZE-1:0]  out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [SIZE-1:0]  out1_data
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] out0_cnt,
  output logic [CNT_W-1:0] out1_cnt
`endif
);
  demux_sel_e w_sel;
  logic       w_full0;
  logic       w_full1;
  logic       w_acc;
  assign w_sel = demux_sel_e'(in_sel);
  // readiness looks only at the selected buffer's registered fullness, so a
  // same-cycle pop never opens a full buffer (no ready-to-ready path)
  assign in_ready = (w_sel == SEL_OUT1) ? ~w_full1 : ~w_full0;
  assign w_acc    = in_valid & in_ready;
  stream_buf2 #(.SIZE(SIZE), .DEPTH(DEPTH)) u_buf0 (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_acc & (w_sel == SEL_OUT0)), .i_data(in_data), .i_pop(out0_ready),
    .o_full(w_full0), .o_valid(out0_valid), .o_data(out0_data)
  );
  stream_buf2 #(.SIZE(SIZE), .DEPTH(DEPTH)) u_buf1 (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_acc & (w_sel == SEL_OUT1)), .i_data(in_data), .i_pop(out1_ready),
    .o_full(w_full1), .o_valid(out1_valid), .o_data(out1_data)
  );
`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (out0_valid & out0_ready) r_cnt0 <= r_cnt0 + 1'b1;
      if (out1_valid & out1_ready) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end
  assign out0_cnt = r_cnt0;
  assign out1_cnt = r_cnt1;
`endif
endmodule

// File: tb/tb_stream_demux_1_2.sv
// tb_stream_demux_1_2: table-driven and scoreboard checks for stream_demux_1_2
module tb_stream_demux_1_2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, in_sel = 1'b0;
  logic [4:0] in_data = '0;
  logic out0_valid, out0_ready = 1'b0, out1_valid, out1_ready = 1'b0;
  logic [4:0] out0_data, out1_data;
`ifdef STREAM_DEMUX_CNT_EN
  logic [15:0] out0_cnt, out1_cnt;
`endif
  int errors = 0;
  int checks = 0;
  logic [4:0] q0[$], q1[$];
  logic [4:0] last0 = '0, last1 = '0;
  logic [15:0] c0 = '0, c1 = '0;

  stream_demux_1_2 #(.SIZE(5), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef STREAM_DEMUX_CNT_EN
    , .out0_cnt(out0_cnt), .out1_cnt(out1_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs();
    chk("out0_valid", out0_valid, q0.size() > 0);
    chk("out0_data", out0_data, q0.size() > 0 ? q0[0] : last0);
    chk("out1_valid", out1_valid, q1.size() > 0);
    chk("out1_data", out1_data, q1.size() > 0 ? q1[0] : last1);
`ifdef STREAM_DEMUX_CNT_EN
    chk("out0_cnt", out0_cnt, c0);
    chk("out1_cnt", out1_cnt, c1);
`endif
  endtask

  // one clock: drive, compare at negedge against the queue model, then
  // update the model at the rising edge
  task automatic cyc(input logic iv, input logic sel, input logic [4:0] d,
                     input logic r0, input logic r1,
                     output logic o_rdy, output logic o_v0, output logic o_v1);
    logic e_rdy;
    in_valid = iv; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    @(negedge clk);
    e_rdy = sel ? (q1.size() < 2) : (q0.size() < 2);
    chk("in_ready", in_ready, e_rdy);
    chk_outs();
    o_rdy = in_ready; o_v0 = out0_valid; o_v1 = out1_valid;
    @(posedge clk);
    if (q0.size() > 0 && r0) begin last0 = q0.pop_front(); c0++; end
    if (q1.size() > 0 && r1) begin last1 = q1.pop_front(); c1++; end
    if (iv && e_rdy) begin
      if (sel) q1.push_back(d);
      else q0.push_back(d);
    end
    #1;
  endtask

  typedef struct {
    logic iv, sel;
    logic [4:0] d;
    logic r0, r1, erdy, ev0, ev1;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic rdy, v0, v1;
    tbl[0] = '{1'b1, 1'b0, 5'h0A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 5'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 5'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 5'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 5'h04, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, rdy, v0, v1);
    cyc(1'b0, 1'b1, 5'h00, 1'b0, 1'b0, rdy, v0, v1);
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1, rdy, v0, v1);
      chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].erdy);
      chk($sformatf("tbl%0d_v0", i), v0, tbl[i].ev0);
      chk($sformatf("tbl%0d_v1", i), v1, tbl[i].ev1);
    end
    cyc(1'b1, 1'b0, 5'h11, 1'b0, 1'b0, rdy, v0, v1);
    cyc(1'b1, 1'b0, 5'h12, 1'b0, 1'b0, rdy, v0, v1);
    cyc(1'b1, 1'b0, 5'h13, 1'b1, 1'b0, rdy, v0, v1);
    chk("full_pop_blocks", rdy, 0);
    cyc(1'b1, 1'b0, 5'h13, 1'b1, 1'b0, rdy, v0, v1);
    chk("full_pop_next_accept", rdy, 1);
    cyc(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, rdy, v0, v1);
    cyc(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, rdy, v0, v1);
    cyc(1'b0, 1'b0, 5'h00, 1'b1, 1'b0, rdy, v0, v1);
    cyc(1'b1, 1'b0, 5'h15, 1'b0, 1'b0, rdy, v0, v1);
    cyc(1'b1, 1'b1, 5'h16, 1'b0, 1'b0, rdy, v0, v1);
    in_valid = 1'b0;
    @(negedge clk);
    chk_outs();
    #1 rst_n = 1'b0;
    #1;
    q0.delete(); q1.delete();
    last0 = '0; last1 = '0; c0 = '0; c1 = '0;
    chk("rst_async_v0", out0_valid, 0);
    chk("rst_async_v1", out1_valid, 0);
    chk_outs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, rdy, v0, v1);
    chk("post_rst_rdy0", rdy, 1);
    cyc(1'b0, 1'b1, 5'h00, 1'b0, 1'b0, rdy, v0, v1);
    chk("post_rst_rdy1", rdy, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, i[0], 5'(i), 1'b1, 1'b1, rdy, v0, v1);
      chk($sformatf("stream%0d_nostall", i), rdy, 1);
    end
    cyc(1'b0, 1'b0, 5'h00, 1'b1, 1'b1, rdy, v0, v1);
    cyc(1'b0, 1'b0, 5'h00, 1'b1, 1'b1, rdy, v0, v1);
    chk("stream_last0", out0_data, 5'd18);
    chk("stream_last1", out1_data, 5'd19);
`ifdef STREAM_DEMUX_CNT_EN
    chk("stream_cnt0", out0_cnt, 10);
    chk("stream_cnt1", out1_cnt, 10);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
